scan_capture: RTL and testbench

SCAN_CAPTURE -- requirements
Module: scan_capture

---
 rtl/scan_capture.sv | 123 ++++++++++++
 tb/tb_scan_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_capture.sv
// Scan frame capture controller: pulses an upstream scan chain load, shifts
// WIDTH serial bits into a frame, and hands the frame off via valid/ready.
// Frame valid WIDTH+1 cycles after the load pulse; an unconsumed frame blocks
// newer ones, which are dropped and flagged on the sticky overrun bit.
module scan_capture #(
  parameter int WIDTH  = 19,
  parameter int PERIOD = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             single,
  output logic             scan_en,
  input  logic             scan_in,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(PERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    per_cnt;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] frame_new;
  logic             last_bit;
  logic             drop;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and the single-cycle load pulse.
  always_comb begin
    next_state = state;
    scan_en    = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (run || single) next_state = LOAD;
      end
      LOAD: begin
        scan_en    = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == BW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // The next load lands exactly PERIOD cycles after the previous one.
        if (per_cnt == PW'(PERIOD - 1)) next_state = run ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit counter: cleared in the load cycle, advances once per shifted bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 bit_cnt <= '0;
    else if (state == LOAD)  bit_cnt <= '0;
    else if (state == SHIFT) bit_cnt <= bit_cnt + BW'(1);
  end

  // Period counter: zero in the load cycle, counts cycles since that load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     per_cnt <= '0;
    else if (state == IDLE || next_state == LOAD) per_cnt <= '0;
    else                                         per_cnt <= per_cnt + PW'(1);
  end

  // Capture register: one serial bit per shift cycle, in arrival order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cap <= '0;
    else if (state == SHIFT) cap[bit_cnt] <= scan_in;
  end

  // Complete frame including the bit arriving on the closing edge.
  always_comb begin
    frame_new          = cap;
    frame_new[bit_cnt] = scan_in;
  end

  // A completing frame is dropped only if the held frame is not leaving now.
  assign drop = last_bit && frame_valid && !frame_ready;

  // Output frame register and its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (last_bit && !drop) begin
      frame_data  <= frame_new;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_scan_capture.sv
// Bench for scan_capture: upstream scan chain model, cycle-level reference
// model built from "cycles since load" arithmetic, directed then random steps.
module tb_scan_capture;

  localparam int WIDTH  = 19;
  localparam int PERIOD = 32;

  logic             clk = 1'b0;
  logic             rst, run, single, scan_en, scan_in;
  logic             frame_valid, frame_ready, overrun, clr_overrun;
  logic [WIDTH-1:0] frame_data, up_data, up_sr;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;
  bit rnd_data = 1'b0;
  logic [WIDTH-1:0] fa, fb;

  // Reference model state.
  int               m_since;   // cycles since last load, -1 when idle
  logic             m_valid, m_ovr;
  logic [WIDTH-1:0] m_data, m_frame;

  always #5 clk = ~clk;

  scan_capture #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .run(run), .single(single), .scan_en(scan_en),
    .scan_in(scan_in), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Upstream scan block: parallel load on en, then shift out LSB first.
  always @(posedge clk or posedge rst) begin
    if (rst)          up_sr <= '0;
    else if (scan_en) up_sr <= up_data;
    else              up_sr <= up_sr >> 1;
  end
  assign scan_in = up_sr[0];

  // Reference model: loads every PERIOD cycles while run, frame done WIDTH
  // cycles after its load, handshake/overrun rules applied at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since = -1;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_data  = '0;
      m_frame = '0;
    end else begin
      if (clr_overrun) m_ovr = 1'b0;
      if (m_since == WIDTH) begin
        if (m_valid && !frame_ready) m_ovr = 1'b1;
        else begin
          m_data  = m_frame;
          m_valid = 1'b1;
        end
      end else if (m_valid && frame_ready) begin
        m_valid = 1'b0;
      end
      if (m_since == 0) m_frame = up_data;
      if (m_since < 0)                m_since = (run || single) ? 0 : -1;
      else if (m_since == PERIOD - 1) m_since = run ? 0 : -1;
      else                            m_since = m_since + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("scan_en",     32'(scan_en),     32'(m_since == 0));
    chk("frame_valid", 32'(frame_valid), 32'(m_valid));
    chk("frame_data",  32'(frame_data),  32'(m_data));
    chk("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  // Advance n cycles; outputs checked 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (scan_en === 1'b1) pulses++;
      check_model();
      if (rnd_data) up_data = WIDTH'($urandom);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; single = 1'b0; frame_ready = 1'b0;
    clr_overrun = 1'b0; up_data = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_scan_en", 32'(scan_en), 32'd0);
    chk("reset_valid",   32'(frame_valid), 32'd0);
    chk("reset_data",    32'(frame_data), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);

    // One-cycle run pulse, fixed upstream pattern.
    up_data = 19'h5A5A5; frame_ready = 1'b1;
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("oneshot_load", 32'(scan_en), 32'd1);
    step(WIDTH);
    chk("oneshot_not_yet", 32'(frame_valid), 32'd0);
    step(1);
    chk("oneshot_valid", 32'(frame_valid), 32'd1);
    chk("oneshot_data", 32'(frame_data), 32'h5A5A5);
    p0 = pulses;
    step(3 * PERIOD);
    chk("oneshot_no_reload", 32'(pulses - p0), 32'd0);

    // Continuous run with random upstream data.
    rnd_data = 1'b1;
    run = 1'b1;
    step(1);
    chk("run_first_load", 32'(scan_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      p0 = pulses;
      step(PERIOD);
      chk("run_gap_load", 32'(scan_en), 32'd1);
      chk("run_pulses_per_period", 32'(pulses - p0), 32'd1);
    end
    run = 1'b0;
    step(2 * PERIOD);
    rnd_data = 1'b0;

    // Consumer stalled: second frame dropped, overrun set then cleared.
    frame_ready = 1'b0;
    fa = WIDTH'($urandom); fb = WIDTH'($urandom);
    up_data = fa; run = 1'b1;
    step(1);
    step(1);
    up_data = fb;
    step(WIDTH);
    chk("stall_first_valid", 32'(frame_valid), 32'd1);
    chk("stall_first_data", 32'(frame_data), 32'(fa));
    step(PERIOD - WIDTH - 1);
    chk("stall_second_load", 32'(scan_en), 32'd1);
    run = 1'b0;
    step(WIDTH + 1);
    chk("stall_overrun", 32'(overrun), 32'd1);
    chk("stall_data_kept", 32'(frame_data), 32'(fa));
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("stall_overrun_clr", 32'(overrun), 32'd0);
    step(PERIOD);
    frame_ready = 1'b1;
    step(2);
    frame_ready = 1'b0;

    // Ready only on the second completion edge: replace, no overrun.
    fa = WIDTH'($urandom); fb = WIDTH'($urandom);
    up_data = fa; run = 1'b1;
    step(1);
    step(1);
    up_data = fb;
    step(PERIOD - 1);
    run = 1'b0;
    step(WIDTH);
    chk("replace_held_data", 32'(frame_data), 32'(fa));
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    chk("replace_valid", 32'(frame_valid), 32'd1);
    chk("replace_data", 32'(frame_data), 32'(fb));
    chk("replace_no_overrun", 32'(overrun), 32'd0);
    step(PERIOD);
    frame_ready = 1'b1;
    step(2);

    // Single-shot capture; single during SHIFT is ignored.
    up_data = 19'h7FFFF;
    single = 1'b1;
    step(1);
    single = 1'b0;
    chk("single_load", 32'(scan_en), 32'd1);
    p0 = pulses;
    step(4);
    single = 1'b1;
    step(1);
    single = 1'b0;
    step(WIDTH - 4);
    chk("single_valid", 32'(frame_valid), 32'd1);
    chk("single_data", 32'(frame_data), 32'h7FFFF);
    step(2 * PERIOD);
    chk("single_no_extra_load", 32'(pulses - p0), 32'd0);

    // Reset mid-frame with a held frame, then a fresh capture.
    frame_ready = 1'b0;
    up_data = WIDTH'($urandom);
    run = 1'b1;
    step(1);
    step(PERIOD - 1);
    run = 1'b0;
    step(11);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    chk("midrst_scan_en", 32'(scan_en), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_data", 32'(frame_data), 32'd0);
    step(2);
    rst = 1'b0;
    frame_ready = 1'b1;
    fa = WIDTH'($urandom);
    up_data = fa; run = 1'b1;
    step(1);
    run = 1'b0;
    chk("postrst_load", 32'(scan_en), 32'd1);
    step(WIDTH + 1);
    chk("postrst_valid", 32'(frame_valid), 32'd1);
    chk("postrst_data", 32'(frame_data), 32'(fa));

    // Random control traffic against the model.
    rnd_data = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      single      = ($urandom_range(0, 15) == 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      clr_overrun = ($urandom_range(0, 9) == 0);
      step(1);
    end
    run = 1'b0; single = 1'b0; clr_overrun = 1'b0; frame_ready = 1'b1;
    step(2 * PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
